// File: rtl/hcsr04_interface.sv
// rtl/hcsr04_interface.sv - HC-SR04 trigger/echo timing front-end with BCD centimetre result
module hcsr04_interface #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [2:0]  db_estado
);

  localparam int TW = $clog2(CYCLES_PER_CM + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(TRIGGER_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_CM - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CYCLES_PER_CM / 2);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] TRIG_LAST = GW'(TRIGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    INICIAL       = 3'b000,
    PREPARACAO    = 3'b001,
    ENVIA_TRIGGER = 3'b010,
    ESPERA_ECHO   = 3'b011,
    MEDE          = 3'b100,
    ARMAZENA      = 3'b101,
    FINAL_MEDIDA  = 3'b110,
    ERRO_ST       = 3'b111
  } state_t;

  state_t        state;
  logic          echo_m;
  logic          echo_s;
  logic [TW-1:0] tick;
  logic [11:0]   bcd;
  logic [WW-1:0] watchdog;
  logic [GW-1:0] trig_cnt;
  logic [TW-1:0] tick_next;
  logic [11:0]   bcd_next;

  // Three-digit BCD increment that sticks at 999 instead of wrapping.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    tick_next = tick + 1'b1;
    bcd_next  = bcd;
    if (tick == TICK_LAST) begin
      tick_next = '0;
      bcd_next  = bcd_inc(bcd);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INICIAL;
      trigger  <= 1'b0;
      medida   <= 12'h000;
      pronto   <= 1'b0;
      erro     <= 1'b0;
      tick     <= '0;
      bcd      <= 12'h000;
      watchdog <= '0;
      trig_cnt <= '0;
    end else begin
      pronto <= 1'b0;
      case (state)
        INICIAL: begin
          if (medir) state <= PREPARACAO;
        end
        PREPARACAO: begin
          tick     <= '0;
          bcd      <= 12'h000;
          watchdog <= '0;
          erro     <= 1'b0;
          trig_cnt <= '0;
          trigger  <= 1'b1;
          state    <= ENVIA_TRIGGER;
        end
        ENVIA_TRIGGER: begin
          if (trig_cnt == TRIG_LAST) begin
            trigger <= 1'b0;
            state   <= ESPERA_ECHO;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end
        // The sample that detects the echo rise is itself counted, so counted width equals raw width.
        ESPERA_ECHO, MEDE: begin
          watchdog <= watchdog + 1'b1;
          if (watchdog == WD_LAST) begin
            state  <= ERRO_ST;
            pronto <= 1'b1;
            erro   <= 1'b1;
          end else if (echo_s) begin
            tick  <= tick_next;
            bcd   <= bcd_next;
            state <= MEDE;
          end else if (state == MEDE) begin
            state <= ARMAZENA;
          end
        end
        ARMAZENA: begin
          medida <= (tick >= TICK_HALF) ? bcd_inc(bcd) : bcd;
          pronto <= 1'b1;
          state  <= FINAL_MEDIDA;
        end
        FINAL_MEDIDA, ERRO_ST: begin
          state <= INICIAL;
        end
        default: state <= INICIAL;
      endcase
    end
  end

  assign db_estado = state;

endmodule

// File: doc/hcsr04_interface.md
# hcsr04_interface

Ultrasonic ranging front-end for the trena datapath. On a `medir` request it fires a trigger pulse into the HC-SR04 sensor, times the returned echo pulse, and converts the width to a 3-digit BCD distance in centimetres, rounded to the nearest cm. It sits directly upstream of the trena control unit and ASCII sender. It drives that unit's `pronto_medida` input, and `medida` feeds the digit-to-ASCII mux.

## Interface
Parameters:
- `TRIGGER_CYCLES`, 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `CYCLES_PER_CM`, 2941: echo clocks per centimetre (58.82 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_500_000: watchdog limit in clocks (30 ms at 50 MHz).

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `medir`, in, 1: measurement request; level-sampled while idle.
- `echo`, in, 1: raw sensor echo; asynchronous to `clock`.
- `trigger`, out, 1: sensor trigger.
- `medida`, out, 12: BCD distance as {hundreds, tens, units}.
- `pronto`, out, 1: one-cycle completion pulse, asserted on success or error.
- `erro`, out, 1: last measurement timed out.
- `db_estado`, out, 3: current state code, for debug.

## Operation
- `echo` passes through a 2-flop synchronizer, producing `echo_s`. All decisions use `echo_s`.
- States and transitions (state code in parentheses):
  - inicial (000): leave to preparacao when `medir`=1.
  - preparacao (001): clear the tick counter, BCD counter, watchdog and `erro`. Next state is envia_trigger.
  - envia_trigger (010): `trigger`=1 for exactly `TRIGGER_CYCLES` cycles, then espera_echo.
  - espera_echo (011): go to mede on `echo_s`=1. Go to erro_st when the watchdog reaches `TIMEOUT_CYCLES`.
  - mede (100): count while `echo_s`=1.
    - Go to armazena on `echo_s`=0.
    - Go to erro_st when the watchdog reaches `TIMEOUT_CYCLES`.
  - armazena (101): load `medida` from the BCD counter plus rounding. Next state is final_medida.
  - final_medida (110): `pronto`=1, then inicial.
  - erro_st (111): `pronto`=1 and set `erro`=1. `medida` keeps its previous value. Next state is inicial.
- Watchdog: one counter runs from entry to espera_echo through the end of mede. It is not reset at echo rise.
- Counting in mede:
  - The tick counter runs from 0 to `CYCLES_PER_CM`-1 and wraps.
  - On each wrap the BCD counter increments, with per-digit carry 9→0.
- Rounding in armazena: if the residual tick count is ≥ `CYCLES_PER_CM`/2 (integer division), add 1 cm.
- Saturation: the BCD counter and the rounded result both saturate at 999. They never wrap to 000.
- Requests are ignored outside inicial. `medir` held high after completion starts a new measurement from inicial.
- `erro` holds its value until the next preparacao. `medida` changes only in armazena.

## Timing
- Reset values: state inicial, `trigger`=0, `medida`=12'h000, `pronto`=0, `erro`=0, `db_estado`=000, all counters 0.
- Reset mid-operation: `trigger` drops immediately (asynchronous). No `pronto` pulse is produced.
- Request to trigger: with `medir` sampled high at edge N, preparacao occupies cycle N+1. `trigger` is high in cycles N+2 through N+1+`TRIGGER_CYCLES`.
- Echo input latency: 2 cycles of synchronizer delay. Counted width equals the raw echo width. An echo already high when espera_echo is entered starts counting immediately.
- End of measurement: echo fall is seen in `echo_s` 2 cycles after the raw fall. armazena follows in the next cycle, and `pronto` the cycle after that. `medida` is valid in the same cycle as `pronto` and is held afterward.
- `pronto` is exactly one cycle wide and is registered (Moore).
- Simultaneous watchdog expiry and echo edge: the timeout wins.

## Test plan
Parameters for sim: `TRIGGER_CYCLES`=5, `CYCLES_PER_CM`=10, `TIMEOUT_CYCLES`=2000 unless noted.
- Reset then idle: all outputs hold their reset values, and `db_estado`=000, for 100 cycles.
- `medir` pulse, then `echo` high for 123 cycles → `trigger` high for exactly 5 cycles; `medida`=12'h012; one `pronto` pulse; `erro`=0.
- Echo width 125 cycles → `medida`=12'h013 (rounds up). Echo width 124 cycles → `medida`=12'h012.
- With `TIMEOUT_CYCLES`=20000, echo width 10050 cycles → `medida`=12'h999 (saturated); `erro`=0.
- No echo after a prior result of 12'h012 → `pronto` and `erro`=1 about 2000 cycles after trigger end; `medida` stays 12'h012. The next successful measurement clears `erro`.
- Extra `medir` pulses during mede are ignored, with one `pronto` only. Asserting `reset` during envia_trigger drops `trigger` at once; `pronto` never pulses.
